uart_rx: RTL and testbench

- Serial receiver directly upstream of the command parser.
- Converts the asynchronous 8N1 line on `rx` into one-cycle `uart_data` / `uart_data_valid` byte strobes that the parser consumes.
- Samples each bit at mid-bit with a 3-sample majority vote.
- Rejects false start bits and flags framing errors. No backpressure: every accepted byte is presented exactly once.

---
 rtl/uart_rx.sv | 159 +++++++++++++++
 tb/tb_uart_rx.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a 2-FF synchronizer and 3-sample majority vote.
// Emits one-cycle byte strobes or framing-error strobes. There is no backpressure.
module uart_rx #(
   parameter int unsigned CLKS_PER_BIT = 868
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   output logic [7:0] uart_data,
   output logic       uart_data_valid,
   output logic       framing_error,
   output logic       busy
);

   localparam int unsigned CW   = $clog2(CLKS_PER_BIT);
   localparam int unsigned HALF = CLKS_PER_BIT / 2;

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_START      = 3'd1,
      S_DATA       = 3'd2,
      S_STOP       = 3'd3,
      S_BREAK_WAIT = 3'd4
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic            r_sync1;
   logic            r_rx_s;
   logic [2:0]      r_hist;
   logic [CW-1:0]   r_cnt;
   logic [2:0]      r_bit_idx;
   logic [7:0]      r_shift;

   logic            w_maj;
   logic            w_last;
   logic            w_half;
   logic            w_cnt_clr;
   logic            w_sample;
   logic            w_load;
   logic            w_ferr;

   assign w_maj  = (r_hist[0] & r_hist[1]) | (r_hist[0] & r_hist[2]) | (r_hist[1] & r_hist[2]);
   assign w_last = (r_cnt == CW'(CLKS_PER_BIT - 1));
   assign w_half = (r_cnt == CW'(HALF - 1));

   // Input synchronizer and sample history; idles high so reset does not look like a start bit.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_sync1 <= 1'b1;
         r_rx_s  <= 1'b1;
         r_hist  <= 3'b111;
      end else begin
         r_sync1 <= rx;
         r_rx_s  <= r_sync1;
         r_hist  <= {r_hist[1:0], r_rx_s};
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic and per-cycle control strobes.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_clr   = 1'b0;
      w_sample    = 1'b0;
      w_load      = 1'b0;
      w_ferr      = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            w_cnt_clr = 1'b1;
            if (!r_rx_s) begin
               w_state_nxt = S_START;
            end
         end
         S_START: begin
            if (w_half) begin
               w_cnt_clr   = 1'b1;
               w_state_nxt = w_maj ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (w_last) begin
               w_cnt_clr = 1'b1;
               w_sample  = 1'b1;
               if (r_bit_idx == 3'd7) begin
                  w_state_nxt = S_STOP;
               end
            end
         end
         S_STOP: begin
            if (w_last) begin
               w_cnt_clr = 1'b1;
               if (w_maj) begin
                  w_load      = 1'b1;
                  w_state_nxt = S_IDLE;
               end else begin
                  w_ferr      = 1'b1;
                  w_state_nxt = S_BREAK_WAIT;
               end
            end
         end
         S_BREAK_WAIT: begin
            w_cnt_clr = 1'b1;
            if (r_rx_s) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_cnt_clr   = 1'b1;
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Bit timing counter, bit index and LSB-first shift register.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_cnt     <= '0;
         r_bit_idx <= 3'd0;
         r_shift   <= 8'd0;
      end else begin
         r_cnt <= w_cnt_clr ? '0 : r_cnt + CW'(1);
         if (r_state != S_DATA) begin
            r_bit_idx <= 3'd0;
         end else if (w_sample) begin
            r_bit_idx <= r_bit_idx + 3'd1;
         end
         if (w_sample) begin
            r_shift <= {w_maj, r_shift[7:1]};
         end
      end
   end

   // Registered outputs: data holds between strobes, strobes last one cycle.
   always_ff @(posedge clk) begin
      if (!reset) begin
         uart_data       <= 8'd0;
         uart_data_valid <= 1'b0;
         framing_error   <= 1'b0;
         busy            <= 1'b0;
      end else begin
         if (w_load) begin
            uart_data <= r_shift;
         end
         uart_data_valid <= w_load;
         framing_error   <= w_ferr;
         busy            <= (w_state_nxt != S_IDLE);
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames with a scoreboard queue checked by an independent monitor.
module tb_uart_rx;

   localparam int unsigned CPB = 16;

   typedef struct {
      bit         ferr;
      logic [7:0] data;
   } ev_t;

   logic       clk;
   logic       reset;
   logic       rx;
   logic [7:0] uart_data;
   logic       uart_data_valid;
   logic       framing_error;
   logic       busy;

   ev_t  exp_q[$];
   int   vtimes[$];
   int   n_cmp;
   int   n_err;
   int   cyc;

   uart_rx #(.CLKS_PER_BIT(CPB)) dut (
      .clk             (clk),
      .reset           (reset),
      .rx              (rx),
      .uart_data       (uart_data),
      .uart_data_valid (uart_data_valid),
      .framing_error   (framing_error),
      .busy            (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Advance one clock; inputs change 1 time unit after the edge.
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Send one 8N1 frame; spike_bit/rst_bit select a 1-clock disturbance at mid-bit (-1 = none).
   task automatic send_byte(input logic [7:0] d, input logic stop, input int spike_bit, input int rst_bit);
      rx = 1'b0;
      tick(CPB);
      for (int b = 0; b < 8; b++) begin
         rx = d[b];
         if (b == spike_bit) begin
            tick(CPB / 2);
            rx = ~d[b];
            tick(1);
            rx = d[b];
            tick(CPB / 2 - 1);
         end else if (b == rst_bit) begin
            tick(CPB / 2);
            reset = 1'b0;
            tick(1);
            reset = 1'b1;
            tick(CPB / 2 - 1);
         end else begin
            tick(CPB);
         end
      end
      rx = stop;
      tick(CPB);
   endtask

   task automatic push_exp(input bit ferr, input logic [7:0] d);
      ev_t e;
      e.ferr = ferr;
      e.data = d;
      exp_q.push_back(e);
   endtask

   // Bounded wait for all expected events to be observed.
   task automatic wait_drain(input string name);
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 400) begin
         tick(1);
         t++;
      end
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL %s: %0d expected events never seen (timeout)", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   // Monitor: pops expected events whenever the DUT strobes.
   always @(negedge clk) begin
      if (reset && (uart_data_valid || framing_error)) begin
         ev_t e;
         n_cmp++;
         if (uart_data_valid && framing_error) begin
            n_err++;
            $display("FAIL strobe_excl: valid and framing_error both high at cycle %0d", cyc);
         end else if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_strobe: valid=%0b ferr=%0b data=0x%0h with nothing expected",
                     uart_data_valid, framing_error, uart_data);
         end else begin
            e = exp_q.pop_front();
            if (uart_data_valid) vtimes.push_back(cyc);
            if (framing_error !== e.ferr || uart_data !== e.data) begin
               n_err++;
               $display("FAIL scoreboard: got ferr=%0b data=0x%0h expected ferr=%0b data=0x%0h",
                        framing_error, uart_data, e.ferr, e.data);
            end
         end
      end
   end

   initial begin
      logic [7:0] burst [5];
      n_cmp = 0;
      n_err = 0;
      cyc   = 0;
      rx    = 1'b1;
      reset = 1'b0;
      burst[0] = 8'h02; burst[1] = 8'h12; burst[2] = 8'h34; burst[3] = 8'h56; burst[4] = 8'h78;
      tick(3);
      check("rst_data",  32'(uart_data), 32'h0);
      check("rst_valid", 32'(uart_data_valid), 32'h0);
      check("rst_ferr",  32'(framing_error), 32'h0);
      check("rst_busy",  32'(busy), 32'h0);
      reset = 1'b1;
      tick(5);

      // Single byte.
      push_exp(1'b0, 8'h01);
      send_byte(8'h01, 1'b1, -1, -1);
      wait_drain("byte_01");
      tick(4);
      check("busy_after_01", 32'(busy), 32'h0);
      check("data_hold_01", 32'(uart_data), 32'h01);

      // Back-to-back burst, zero idle.
      vtimes.delete();
      for (int i = 0; i < 5; i++) push_exp(1'b0, burst[i]);
      for (int i = 0; i < 5; i++) send_byte(burst[i], 1'b1, -1, -1);
      wait_drain("burst");
      check("burst_count", 32'(vtimes.size()), 32'd5);
      if (vtimes.size() == 5) begin
         for (int i = 1; i < 5; i++) check("burst_spacing", 32'(vtimes[i] - vtimes[i-1]), 32'd160);
      end
      tick(CPB);

      // False start: 4-clock low pulse.
      rx = 1'b0;
      tick(4);
      rx = 1'b1;
      tick(10);
      check("false_start_busy", 32'(busy), 32'h0);
      check("false_start_data", 32'(uart_data), 32'h78);
      tick(CPB * 2);

      // Spike in bit 3 corrected by majority.
      push_exp(1'b0, 8'hA5);
      send_byte(8'hA5, 1'b1, 3, -1);
      wait_drain("spike_a5");
      tick(CPB);

      // Framing error followed by a long break, then a clean frame.
      push_exp(1'b1, 8'hA5);
      send_byte(8'h3C, 1'b0, -1, -1);
      rx = 1'b0;
      tick(50 * CPB);
      check("break_busy", 32'(busy), 32'h1);
      check("break_data", 32'(uart_data), 32'hA5);
      rx = 1'b1;
      tick(2 * CPB);
      check("break_recovered", 32'(busy), 32'h0);
      wait_drain("ferr_3c");
      push_exp(1'b0, 8'h02);
      send_byte(8'h02, 1'b1, -1, -1);
      wait_drain("after_ferr_02");
      tick(CPB);

      // Reset mid-frame abandons the byte.
      send_byte(8'hFF, 1'b1, -1, 4);
      tick(2);
      check("abort_data",  32'(uart_data), 32'h0);
      check("abort_valid", 32'(uart_data_valid), 32'h0);
      check("abort_ferr",  32'(framing_error), 32'h0);
      check("abort_busy",  32'(busy), 32'h0);
      tick(CPB);
      push_exp(1'b0, 8'h02);
      send_byte(8'h02, 1'b1, -1, -1);
      wait_drain("after_abort_02");
      tick(CPB);
      check("final_data", 32'(uart_data), 32'h02);
      check("final_queue", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
